// File: rtl/jelly2_img_filter2d_param_ctl_if.sv
// Register-bus bundle for the 2D filter parameter controller.
// JELLY2_IMG_FILTER2D_PARAM_CTL_READBACK_EN adds the shadow read port.
interface jelly2_img_filter2d_param_ctl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int COEFF_WIDTH = 18
);
  logic                    s_wr_en;
  logic [ADDR_WIDTH-1:0]   s_wr_addr;
  logic [COEFF_WIDTH-1:0]  s_wr_data;
`ifdef JELLY2_IMG_FILTER2D_PARAM_CTL_READBACK_EN
  logic [ADDR_WIDTH-1:0]   s_rd_addr;
  logic [COEFF_WIDTH-1:0]  m_rd_data;

  modport master (output s_wr_en, output s_wr_addr, output s_wr_data,
                  output s_rd_addr, input m_rd_data);
  modport slave  (input s_wr_en, input s_wr_addr, input s_wr_data,
                  input s_rd_addr, output m_rd_data);
`else
  modport master (output s_wr_en, output s_wr_addr, output s_wr_data);
  modport slave  (input s_wr_en, input s_wr_addr, input s_wr_data);
`endif
endinterface

// File: rtl/jelly2_img_filter2d_param_ctl.sv
// Shadow/active coefficient bank for the 2D filter, swapped atomically at frame start or on force.
// Optional feature macro: JELLY2_IMG_FILTER2D_PARAM_CTL_READBACK_EN (registered shadow readback).
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | no update requested
// ST_PENDING | update requested, waiting for cke & frame_start
// ST_APPLY   | active bank just loaded; update_ack high
module jelly2_img_filter2d_param_ctl #(
  parameter int                    ROWS        = 3,
  parameter int                    COLS        = 3,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    COEFF_WIDTH = 18,
  parameter int                    COEFF_FRAC  = 16,
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_MIN    = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_MAX    = '1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cke,
  jelly2_img_filter2d_param_ctl_if.slave        s_bus,
  input  logic                                  frame_start,
  output logic signed [ROWS*COLS*COEFF_WIDTH-1:0] param_coeff,
  output logic [DATA_WIDTH-1:0]                 param_min,
  output logic [DATA_WIDTH-1:0]                 param_max,
  output logic                                  update_pending,
  output logic                                  update_ack
);

  localparam int N      = ROWS * COLS;
  localparam int CENTER = (ROWS / 2) * COLS + (COLS / 2);

  localparam logic [ADDR_WIDTH-1:0]  ADR_MIN   = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0]  ADR_MAX   = ADDR_WIDTH'(N + 1);
  localparam logic [ADDR_WIDTH-1:0]  ADR_CTL   = ADDR_WIDTH'(N + 2);
  localparam logic [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_pending;
  logic                    r_ack;

  logic [COEFF_WIDTH-1:0]  r_sh_coeff [N];
  logic [DATA_WIDTH-1:0]   r_sh_min;
  logic [DATA_WIDTH-1:0]   r_sh_max;
  logic [COEFF_WIDTH-1:0]  r_act_coeff [N];
  logic [DATA_WIDTH-1:0]   r_act_min;
  logic [DATA_WIDTH-1:0]   r_act_max;

  logic                    w_ctl_req;
  logic                    w_ctl_force;
  logic                    w_load;

  assign w_ctl_req   = s_bus.s_wr_en && (s_bus.s_wr_addr == ADR_CTL) && s_bus.s_wr_data[0];
  assign w_ctl_force = s_bus.s_wr_data[1];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ctl_req && w_ctl_force)  w_state_next = ST_APPLY;
        else if (w_ctl_req)            w_state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if ((w_ctl_req && w_ctl_force) || (cke && frame_start)) w_state_next = ST_APPLY;
      end
      ST_APPLY:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign w_load = (w_state_next == ST_APPLY) && (r_state != ST_APPLY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= (w_state_next == ST_PENDING);
      r_ack     <= (w_state_next == ST_APPLY);
    end
  end

  // Shadow writes are accepted in every state; the active copy takes the pre-write shadow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        r_sh_coeff[k]  <= (k == CENTER) ? COEFF_ONE : '0;
        r_act_coeff[k] <= (k == CENTER) ? COEFF_ONE : '0;
      end
      r_sh_min  <= INIT_MIN;
      r_sh_max  <= INIT_MAX;
      r_act_min <= INIT_MIN;
      r_act_max <= INIT_MAX;
    end else begin
      if (w_load) begin
        for (int k = 0; k < N; k++) r_act_coeff[k] <= r_sh_coeff[k];
        r_act_min <= r_sh_min;
        r_act_max <= r_sh_max;
      end
      if (s_bus.s_wr_en) begin
        for (int k = 0; k < N; k++) begin
          if (s_bus.s_wr_addr == ADDR_WIDTH'(k)) r_sh_coeff[k] <= s_bus.s_wr_data;
        end
        if (s_bus.s_wr_addr == ADR_MIN) r_sh_min <= s_bus.s_wr_data[DATA_WIDTH-1:0];
        if (s_bus.s_wr_addr == ADR_MAX) r_sh_max <= s_bus.s_wr_data[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    param_coeff = '0;
    for (int k = 0; k < N; k++) param_coeff[k*COEFF_WIDTH +: COEFF_WIDTH] = r_act_coeff[k];
  end

  assign param_min      = r_act_min;
  assign param_max      = r_act_max;
  assign update_pending = r_pending;
  assign update_ack     = r_ack;

`ifdef JELLY2_IMG_FILTER2D_PARAM_CTL_READBACK_EN
  logic [COEFF_WIDTH-1:0] r_rd_data;
  logic [COEFF_WIDTH-1:0] w_rd_mux;

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < N; k++) begin
      if (s_bus.s_rd_addr == ADDR_WIDTH'(k)) w_rd_mux = r_sh_coeff[k];
    end
    if (s_bus.s_rd_addr == ADR_MIN) w_rd_mux = COEFF_WIDTH'(r_sh_min);
    if (s_bus.s_rd_addr == ADR_MAX) w_rd_mux = COEFF_WIDTH'(r_sh_max);
    if (s_bus.s_rd_addr == ADR_CTL) w_rd_mux = COEFF_WIDTH'({r_pending, r_state});
  end

  always_ff @(posedge clk) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= w_rd_mux;
  end

  assign s_bus.m_rd_data = r_rd_data;
`endif

endmodule
